shared_mem_arbiter: RTL

Round-robin arbiter that shares one single-port data memory between the GPU cores that the task scheduler dispatches work to. Each core issues one read or write at a time over a request/grant/ack handshake. The arbiter serialises requests onto the memory port and returns read data and acks to the right core after the memory's fixed read latency. It also supports a per-core lock so that a read-modify-write sequence runs atomically with respect to the other cores.

---
 rtl/shared_mem_arbiter_if.sv | 31 +++
 rtl/shared_mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter_if.sv
// Core-side request/grant/ack bundle plus the shared memory port of the arbiter.
// The arbiter takes the slave view; the cores and memory together take the master view.
interface shared_mem_arbiter_if #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8
);
   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES-1:0]        core_we;
   logic [NUM_CORES-1:0]        core_lock;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES*DATA_W-1:0] core_wdata;
   logic [NUM_CORES-1:0]        core_gnt;
   logic [NUM_CORES-1:0]        core_ack;
   logic [DATA_W-1:0]           core_rdata;
   logic                        mem_en;
   logic                        mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic [DATA_W-1:0]           mem_rdata;

   modport master (
      output core_req, core_we, core_lock, core_addr, core_wdata, mem_rdata,
      input  core_gnt, core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  core_req, core_we, core_lock, core_addr, core_wdata, mem_rdata,
      output core_gnt, core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between GPU cores, with
// in-order ack return after the fixed memory latency and a per-core atomic lock.
module shared_mem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_LAT   = 1
) (
   input logic                 clk,
   input logic                 reset,
   shared_mem_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_CORES);
   typedef logic [IDX_W-1:0] idx_t;

   idx_t                 rr_ptr;
   idx_t                 lock_owner;
   logic                 lock_valid;
   logic                 lock_release;
   logic                 lock_active;
   logic [NUM_CORES-1:0] eligible;
   logic                 win_found;
   idx_t                 win_idx;
   idx_t                 next_ptr;
   logic [IDX_W:0]       cand;

   logic [MEM_LAT:0]     pipe_valid;
   logic [MEM_LAT:0]     pipe_we;
   idx_t                 pipe_id [MEM_LAT+1];

   // An owner that has gone idle with lock low frees the lock on this very edge,
   // so the other cores compete immediately instead of losing a cycle.
   always_comb begin
      lock_release = lock_valid && !bus.core_lock[lock_owner]
                     && !bus.core_gnt[lock_owner] && !bus.core_req[lock_owner];
      lock_active  = lock_valid && !lock_release;
      eligible     = bus.core_req & ~bus.core_gnt;
      if (lock_active)
         eligible = eligible & (NUM_CORES'(1) << lock_owner);
   end

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_CORES))
            cand = cand - (IDX_W+1)'(NUM_CORES);
         if (!win_found && eligible[cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
      next_ptr = (win_idx == idx_t'(NUM_CORES-1)) ? '0 : win_idx + idx_t'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.core_gnt  <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         rr_ptr        <= '0;
         lock_valid    <= 1'b0;
         lock_owner    <= '0;
      end else begin
         bus.core_gnt <= '0;
         bus.mem_en   <= win_found;
         bus.mem_we   <= 1'b0;
         if (win_found) begin
            bus.core_gnt  <= NUM_CORES'(1) << win_idx;
            bus.mem_we    <= bus.core_we[win_idx];
            bus.mem_addr  <= bus.core_addr[win_idx*ADDR_W +: ADDR_W];
            bus.mem_wdata <= bus.core_wdata[win_idx*DATA_W +: DATA_W];
            rr_ptr        <= next_ptr;
            lock_valid    <= bus.core_lock[win_idx];
            lock_owner    <= win_idx;
         end else if (lock_release) begin
            lock_valid <= 1'b0;
         end
      end
   end

   // Completion pipeline: stage MEM_LAT lines up with mem_rdata, and writes
   // occupy a slot too so acks always come back in grant order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid     <= '0;
         pipe_we        <= '0;
         bus.core_ack   <= '0;
         bus.core_rdata <= '0;
      end else begin
         pipe_valid[0] <= win_found;
         pipe_we[0]    <= bus.core_we[win_idx];
         for (int s = 1; s <= MEM_LAT; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_we[s]    <= pipe_we[s-1];
         end
         bus.core_ack   <= pipe_valid[MEM_LAT] ? (NUM_CORES'(1) << pipe_id[MEM_LAT]) : '0;
         bus.core_rdata <= (pipe_valid[MEM_LAT] && !pipe_we[MEM_LAT]) ? bus.mem_rdata : '0;
      end
   end

   always_ff @(posedge clk) begin
      pipe_id[0] <= win_idx;
      for (int s = 1; s <= MEM_LAT; s++)
         pipe_id[s] <= pipe_id[s-1];
   end
endmodule
